// File: rtl/demux_deserializer_pkg.sv
// rtl/demux_deserializer_pkg.sv - shared types for the round-robin deserializer
package demux_deserializer_pkg;

  // FILL: collecting lane words; HOLD: wide word presented to the consumer
  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/demux_deserializer_demux.sv
// rtl/demux_deserializer_demux.sv - 1-to-N one-hot lane write decoder
module demux_deserializer_demux #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [SW-1:0] sel,
  input  logic          en,
  output logic [N-1:0]  we
);

  // raise exactly one write enable for the selected lane when enabled
  always_comb begin
    we = '0;
    if (en) we[sel] = 1'b1;
  end

endmodule

// File: rtl/demux_deserializer.sv
// rtl/demux_deserializer.sv - narrow stream to N-lane wide word deserializer
module demux_deserializer
  import demux_deserializer_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data,
  output logic [N-1:0]   out_keep,
  output logic           out_last
);

  localparam int IW = $clog2(N);

  state_t        state;
  logic [IW-1:0] idx;
  logic [N-1:0]  lane_we;
  logic          acc;
  logic          take;
  logic          fill_acc;

  // in_ready looks only at state and out_ready so the producer sees no loop
  always_comb begin
    out_valid = (state == HOLD);
    in_ready  = (state == FILL) ? 1'b1 : out_ready;
    acc       = in_valid && in_ready;
    take      = out_valid && out_ready;
    fill_acc  = acc && (state == FILL);
  end

  demux_deserializer_demux #(.N(N), .SW(IW)) u_demux (
    .sel (idx),
    .en  (fill_acc),
    .we  (lane_we)
  );

  // lane fill, group close, and hand-off to the consumer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      idx      <= '0;
      out_data <= '0;
      out_keep <= '0;
      out_last <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (acc) begin
            for (int k = 0; k < N; k++) begin
              if (lane_we[k]) out_data[k*W +: W] <= in_data;
            end
            out_keep <= out_keep | lane_we;
            if (idx == IW'(N-1) || in_last) begin
              state    <= HOLD;
              out_last <= in_last;
              idx      <= '0;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        HOLD: begin
          if (take) begin
            if (acc) begin
              // the word arriving with the hand-off opens the next group in lane 0
              out_data <= {{((N-1)*W){1'b0}}, in_data};
              out_keep <= {{(N-1){1'b0}}, 1'b1};
              if (in_last) begin
                state    <= HOLD;
                out_last <= 1'b1;
                idx      <= '0;
              end else begin
                state    <= FILL;
                out_last <= 1'b0;
                idx      <= IW'(1);
              end
            end else begin
              state    <= FILL;
              out_data <= '0;
              out_keep <= '0;
              out_last <= 1'b0;
              idx      <= '0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_deserializer.sv
// tb/tb_demux_deserializer.sv - randomized self-checking bench for demux_deserializer
module tb_demux_deserializer;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic           in_last = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_keep;
  logic           out_last;

  int vectors = 0;
  int miscompares = 0;

  // reference model: words of the open group, plus the presented wide word
  logic [W-1:0]   cur[$];
  logic           held = 1'b0;
  logic [N*W-1:0] held_data = '0;
  logic [N-1:0]   held_keep = '0;
  logic           held_last = 1'b0;

  demux_deserializer #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock: drive, check against the model, then advance the model
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic l, input logic r);
    logic exp_ready;
    @(negedge clk);
    in_valid = v; in_data = d; in_last = l; out_ready = r;
    #1;
    exp_ready = !held || r;
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    chk("out_valid", 64'(out_valid), 64'(held));
    if (held) begin
      chk("out_data", 64'(out_data), 64'(held_data));
      chk("out_keep", 64'(out_keep), 64'(held_keep));
      chk("out_last", 64'(out_last), 64'(held_last));
    end
    if (held && r) held = 1'b0;
    if (v && exp_ready) begin
      cur.push_back(d);
      if (cur.size() == N || l) begin
        held_data = '0;
        held_keep = '0;
        for (int i = 0; i < cur.size(); i++) begin
          held_data[i*W +: W] = cur[i];
          held_keep[i] = 1'b1;
        end
        held_last = l;
        held = 1'b1;
        cur.delete();
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_keep", 64'(out_keep), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    held = 1'b0;
    cur.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // full group
    cycle(1, 8'h11, 0, 1); cycle(1, 8'h22, 0, 1);
    cycle(1, 8'h33, 0, 1); cycle(1, 8'h44, 0, 1);
    cycle(0, 8'h00, 0, 0);
    chk("g1_data", 64'(out_data), 64'h44332211);
    chk("g1_keep", 64'(out_keep), 64'hf);
    chk("g1_last", 64'(out_last), 64'd0);
    cycle(0, 8'h00, 0, 1);

    // early close
    cycle(1, 8'hA1, 0, 1); cycle(1, 8'hA2, 1, 1);
    cycle(0, 8'h00, 0, 0);
    chk("g2_data", 64'(out_data), 64'h0000A2A1);
    chk("g2_keep", 64'(out_keep), 64'h3);
    chk("g2_last", 64'(out_last), 64'd1);
    cycle(0, 8'h00, 0, 1);

    // back-to-back, no bubbles
    for (int i = 1; i <= 8; i++) cycle(1, 8'(i), 0, 1);
    cycle(0, 8'h00, 0, 1);

    // backpressure with pending input
    for (int i = 0; i < 4; i++) cycle(1, 8'hC0 + 8'(i), 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, 8'h99, 0, 0);
    cycle(1, 8'h99, 0, 1);
    cycle(0, 8'h00, 0, 0);
    chk("bp_keep", 64'(out_keep), 64'h1);
    chk("bp_lane0", 64'(out_data[W-1:0]), 64'h99);
    cycle(1, 8'h9A, 1, 1);
    cycle(0, 8'h00, 0, 1);

    // in_last on the first word
    cycle(1, 8'h5A, 1, 1);
    cycle(0, 8'h00, 0, 0);
    chk("first_last_data", 64'(out_data), 64'h0000005A);
    chk("first_last_keep", 64'(out_keep), 64'h1);
    chk("first_last_last", 64'(out_last), 64'd1);
    cycle(0, 8'h00, 0, 1);

    // reset mid-group discards partial words
    cycle(1, 8'h77, 0, 1); cycle(1, 8'h88, 0, 1);
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 0, 1);
    cycle(0, 8'h00, 0, 0);
    chk("post_rst_data", 64'(out_data), 64'h04030201);
    chk("post_rst_keep", 64'(out_keep), 64'hf);
    cycle(0, 8'h00, 0, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 9) < 2),
            ($urandom_range(0, 9) < 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
